adam_clk_div_mon: RTL and testbench

ADAM_CLK_DIV_MON -- requirements
Module: adam_clk_div_mon

---
 rtl/adam_clk_div_mon.sv | 160 ++++++++++++++++
 tb/tb_adam_clk_div_mon.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adam_clk_div_mon.sv
// adam_clk_div_mon: measures the period of an asynchronous divided clock in
// clk cycles, declares lock after a run of matching measurements, and flags
// loss when no rising edge arrives within TIMEOUT cycles.
module adam_clk_div_mon #(
  parameter int WIDTH      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [WIDTH-1:0] TOL_W     = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [3:0]       LOCK_W    = 4'(LOCK_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    ACQ,
    MEAS,
    LOCKED,
    LOST
  } state_t;

  state_t           state;
  logic             sync1, sync2, dly;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ref_per;
  logic [3:0]       match;
  logic [WIDTH-1:0] diff;
  logic             is_match;
  logic             timeout;
  logic [3:0]       match_nxt;

  // Two-flop synchronizer plus one delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise = sync2 & ~dly;

  // Cycles since the last rise; restarts at 1 on a rise, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= WIDTH'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Measurement comparison against the reference period and timeout detect
  always_comb begin
    diff      = (cnt >= ref_per) ? (cnt - ref_per) : (ref_per - cnt);
    is_match  = (diff <= TOL_W);
    timeout   = ~rise && (cnt == TIMEOUT_W);
    // match == 0 means no measurement yet: the next one becomes the reference
    match_nxt = ((match != '0) && is_match) ? (match + 1'b1) : 4'd1;
  end

  // Monitor FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ref_per      <= '0;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        match  <= '0;
        locked <= 1'b0;
        lost   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQ;
          end
          ACQ: begin
            if (rise) begin
              state <= MEAS;
              match <= '0;
            end else if (timeout) begin
              state  <= LOST;
              lost   <= 1'b1;
              locked <= 1'b0;
            end
          end
          MEAS: begin
            if (rise) begin
              match <= match_nxt;
              if (match_nxt == 4'd1) begin
                ref_per <= cnt;
              end
              if (match_nxt == LOCK_W) begin
                state        <= LOCKED;
                period       <= cnt;
                period_valid <= 1'b1;
                locked       <= 1'b1;
              end
            end else if (timeout) begin
              state  <= LOST;
              lost   <= 1'b1;
              locked <= 1'b0;
            end
          end
          LOCKED: begin
            if (rise) begin
              if (is_match) begin
                period       <= cnt;
                period_valid <= 1'b1;
              end else begin
                state   <= MEAS;
                locked  <= 1'b0;
                ref_per <= cnt;
                match   <= 4'd1;
              end
            end else if (timeout) begin
              state  <= LOST;
              lost   <= 1'b1;
              locked <= 1'b0;
            end
          end
          LOST: begin
            if (rise) begin
              state <= MEAS;
              lost  <= 1'b0;
              match <= '0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adam_clk_div_mon.sv
// Bench for adam_clk_div_mon: an event-level reference model predicts every
// period_valid pulse and status change with its cycle; a monitor compares.
module tb_adam_clk_div_mon;

  localparam int W  = 8;
  localparam int LC = 4;
  localparam int TL = 0;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         in;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         lost;

  adam_clk_div_mon #(.WIDTH(W), .LOCK_COUNT(LC), .TOL(TL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in(in),
    .period(period), .period_valid(period_valid), .locked(locked), .lost(lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // kind: 0 = period_valid pulse (val = period), 1 = locked change, 2 = lost change
  typedef struct { int kind; int val; int stamp; } ev_t;
  ev_t expq[$];

  function automatic bit close(int a, int b);
    return ((a > b) ? (a - b) : (b - a)) <= TL;
  endfunction

  // Reference model: mode 0 off, 1 waiting for first edge, 2 measuring,
  // 3 locked, 4 lost. A rise becomes visible 3 clk edges after it is sampled.
  int mmode = 0;
  int run[$];
  int last = 0;
  bit was_rst = 1'b1;
  bit h1, h2, h3;
  int e_locked = 0;
  int e_lost   = 0;

  always @(posedge clk) begin : model
    int cntv;
    bit r;
    int nl, nlost, np;
    bit pv;
    cyc = cyc + 1;
    if (rst) begin
      mmode = 0; run.delete(); h1 = 0; h2 = 0; h3 = 0;
      e_locked = 0; e_lost = 0; was_rst = 1'b1;
    end else begin
      if (was_rst) begin last = cyc; was_rst = 1'b0; end
      r = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = in;
      cntv = cyc - last;
      if (cntv > 255) cntv = 255;
      if (r) last = cyc;
      nl = e_locked; nlost = e_lost; np = 0; pv = 1'b0;
      if (!enable) begin
        mmode = 0; nl = 0; nlost = 0;
      end else begin
        case (mmode)
          0: mmode = 1;
          1: begin
            if (r) begin mmode = 2; run.delete(); end
            else if (cntv == TO) begin mmode = 4; nlost = 1; nl = 0; end
          end
          2: begin
            if (r) begin
              if (run.size() != 0 && !close(cntv, run[0])) run.delete();
              run.push_back(cntv);
              if (run.size() == LC) begin mmode = 3; nl = 1; np = cntv; pv = 1'b1; end
            end else if (cntv == TO) begin mmode = 4; nlost = 1; nl = 0; end
          end
          3: begin
            if (r) begin
              if (close(cntv, run[0])) begin np = cntv; pv = 1'b1; end
              else begin nl = 0; mmode = 2; run.delete(); run.push_back(cntv); end
            end else if (cntv == TO) begin mmode = 4; nlost = 1; nl = 0; end
          end
          default: begin
            if (r) begin mmode = 2; run.delete(); nlost = 0; end
          end
        endcase
      end
      if (pv) expq.push_back('{0, np, cyc});
      if (nl != e_locked) expq.push_back('{1, nl, cyc});
      if (nlost != e_lost) expq.push_back('{2, nlost, cyc});
      e_locked = nl; e_lost = nlost;
    end
  end

  // Monitor: every observed pulse or status change must match the queue head
  int p_locked = 0, p_lost = 0, p_period = 0;

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, required none", kind, val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val != val || e.stamp != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.stamp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      p_locked = 0; p_lost = 0; p_period = 0;
    end else begin
      if (period_valid) check_ev(0, int'(period));
      else if (int'(period) != p_period) begin
        checks++; errors++;
        $display("FAIL period_change: got %0d without pulse, required %0d", period, p_period);
      end
      if (int'(locked) != p_locked) check_ev(1, int'(locked));
      if (int'(lost) != p_lost) check_ev(2, int'(lost));
      while (expq.size() > 0 && expq[0].stamp <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_event: got nothing at cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                 cyc, expq[0].kind, expq[0].val, expq[0].stamp);
        void'(expq.pop_front());
      end
      p_locked = int'(locked); p_lost = int'(lost); p_period = int'(period);
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic drive(input bit v, input int n);
    @(negedge clk);
    in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic tog(input int hi, input int lo, input int n);
    repeat (n) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_period_valid"}, int'(period_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_lost"}, int'(lost), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; in = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // lock at period 10, change to 12, back to 10
    tog(5, 5, 10);
    tog(6, 6, 8);
    tog(5, 5, 6);
    // loss of clock and recovery
    drive(1'b0, 130);
    tog(5, 5, 8);
    // timeout boundary: period 100 survives, period 101 is lost
    tog(50, 50, 7);
    tog(50, 51, 2);
    tog(5, 5, 8);

    // enable drop while locked: status clears, period held
    chk("locked_before_drop", int'(locked), 1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_locked", int'(locked), 0);
    chk("drop_period", int'(period), 10);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    tog(5, 5, 8);

    // reset mid-measurement: outputs clear immediately
    drive(1'b1, 3);
    chk("locked_before_rst", int'(locked), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    tog(5, 5, 8);

    // randomized segments with occasional enable drops and long gaps
    repeat (8) begin
      tog($urandom_range(2, 9), $urandom_range(2, 9), $urandom_range(3, 8));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        enable = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) drive(1'b0, $urandom_range(95, 140));
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
